pc_fetch_unit: RTL

Parametrised fetch-address generator and in-flight tracker for the IF stage. Produces the sequential or redirected fetch address, issues it to instruction memory with a req/gnt handshake, tracks up to DEPTH outstanding requests in a tag FIFO, and delivers each response to decode tagged with its PC and fetch exception. Redirects (flush, branch) are never lost: stale in-flight fetches are squashed and a redirect arriving mid-handshake is held until the handshake completes.

---
 rtl/pc_fetch_unit_pkg.sv | 25 ++
 rtl/pc_tag_fifo.sv | 62 ++++++
 rtl/pc_fetch_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the IF-stage fetch unit: FSM encoding, tag FIFO entry
// layout, reset vector and the exception bus layout used on out_excp.
package pc_fetch_unit_pkg;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // FIFO entries always carry a full 32-bit pc; narrower ADDR_W is zero-extended.
    localparam int PC_W = 32;

    // Exception bus: one bit per cause, instruction-fetch address error at EXC_I_ADEL.
    localparam int EXC_W      = 8;
    localparam int EXC_I_ADEL = 4;
    localparam logic [EXC_W-1:0] EXC_ADEL_MASK = EXC_W'(1) << EXC_I_ADEL;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [EXC_W-1:0] excp;
        logic             drop;
    } tag_entry_t;

endpackage

// File: rtl/pc_tag_fifo.sv
// In-order tracker of outstanding fetches. set_drop marks every stored entry
// stale in one cycle so that redirects squash all in-flight responses.
module pc_tag_fifo
    import pc_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  tag_entry_t       push_entry,
    input  logic             pop,
    input  logic             set_drop,
    output tag_entry_t       head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    tag_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_valid = (count != '0);
    assign head       = mem[rd_ptr];
    assign do_pop     = pop & head_valid;
    assign do_push    = push & (count != CNT_W'(DEPTH));

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Entry storage; the pushed entry carries its own drop bit and wins over the broadcast.
    always_ff @(posedge clk) begin
        if (set_drop) begin
            for (int i = 0; i < DEPTH; i++) mem[i].drop <= 1'b1;
        end
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage fetch-address generator with req/gnt issue and in-flight tracking.
// Optional build macro PC_UMCHECK_EN: flags user-mode fetches from the kernel
// segment (pc[ADDR_W-1] set) as address errors; without it only alignment is checked.
//
// state | meaning
// RUN   | no request pending; decide to issue, fault, or wait
// HOLD  | i_req high with i_addr stable until i_gnt
// ERR   | faulting pc pushed, no fetching until a redirect
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                FETCH_N  = 1,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              br_flag,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              usermode,
    output logic              i_req,
    output logic [ADDR_W-1:0] i_addr,
    input  logic              i_gnt,
    input  logic              i_rvalid,
    output logic              i_rready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [EXC_W-1:0]  out_excp,
    input  logic              out_ready
);

    localparam int                CNT_W  = $clog2(DEPTH + 1);
    localparam int                OCC_W  = CNT_W + 1;
    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(4 * FETCH_N);

    logic [1:0]        state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] pend_pc, pend_pc_n;
    logic              pend_valid, pend_valid_n;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] cand;
    logic              cand_bad;
    logic              um_check;
    logic              granted;
    logic              room;
    logic              can_issue;
    logic [OCC_W-1:0]  occ;

    tag_entry_t        head;
    tag_entry_t        push_entry;
    logic              head_valid;
    logic              head_exc;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;

`ifdef PC_UMCHECK_EN
    assign um_check = usermode;
`else
    logic unused_usermode;
    assign um_check        = 1'b0;
    assign unused_usermode = usermode;
`endif

    assign redirect = flush | br_flag;
    assign target   = flush ? flush_pc : br_addr;
    assign seq_pc   = (pc & ~(STEP_V - ADDR_W'(1))) + STEP_V;
    assign granted  = (state == ST_HOLD) & i_gnt;

    // Address the FSM will sit on next cycle; a pending redirect replaces the sequential step.
    assign cand = redirect                          ? target  :
                  (state == ST_HOLD && pend_valid)  ? pend_pc :
                  (state == ST_HOLD)                ? seq_pc  : pc;
    assign cand_bad = (cand[1:0] != 2'b00) | (um_check & cand[ADDR_W-1]);

    // Occupancy after this cycle's pop and any grant push decides whether another request fits.
    assign occ       = {1'b0, count} - OCC_W'(pop) + OCC_W'(granted);
    assign room      = occ < OCC_W'(DEPTH);
    assign can_issue = ~stall & room & ~cand_bad;

    assign head_exc  = |head.excp;
    assign i_rready  = head_valid & ~head_exc & (out_ready | head.drop);
    assign out_valid = head_valid & ~head.drop & (i_rvalid | head_exc) & ~redirect;
    assign out_pc    = head_valid ? ADDR_W'(head.pc) : '0;
    assign out_excp  = head_valid ? head.excp : '0;
    assign pop       = head_valid & (head_exc ? (head.drop | (out_valid & out_ready))
                                              : (i_rvalid & i_rready));

    assign i_req  = (state == ST_HOLD);
    assign i_addr = pc;

    // Next-state, next-pc and FIFO push decision.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pend_valid_n = pend_valid;
        pend_pc_n    = pend_pc;
        push         = 1'b0;
        push_entry   = '0;
        case (state)
            ST_RUN: begin
                if (redirect) begin
                    pc_n    = target;
                    state_n = can_issue ? ST_HOLD : ST_RUN;
                end else if (!stall && room) begin
                    if (cand_bad) begin
                        push            = 1'b1;
                        push_entry.pc   = PC_W'(pc);
                        push_entry.excp = EXC_ADEL_MASK;
                        state_n         = ST_ERR;
                    end else begin
                        state_n = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (granted) begin
                    push            = 1'b1;
                    push_entry.pc   = PC_W'(pc);
                    push_entry.drop = redirect | pend_valid;
                    pend_valid_n    = 1'b0;
                    pc_n            = cand;
                    state_n         = can_issue ? ST_HOLD : ST_RUN;
                end else if (redirect) begin
                    pend_valid_n = 1'b1;
                    pend_pc_n    = target;
                end
            end
            ST_ERR: begin
                if (redirect) begin
                    pc_n    = target;
                    state_n = can_issue ? ST_HOLD : ST_RUN;
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    // FSM, pc and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pend_valid <= pend_valid_n;
            pend_pc    <= pend_pc_n;
        end
    end

    pc_tag_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .set_drop   (redirect),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

endmodule
